bottle_filler: RTL and testbench

- Producer end of the bottle-count interface. Counts pills dropped into the current bottle as a 2-digit BCD value (nowH:nowL) and drives isWork.
- Compares the count against the BCD capacity maxH:maxL. When the bottle reaches capacity, signals full for exactly one cycle, then requests the next empty bottle from the conveyor.
- Its nowL/nowH/isWork outputs feed the downstream full-bottle counter, which shares the same maxL/maxH and EN_work/EN_set/set controls.

---
 rtl/bottle_filler_if.sv | 34 +++
 rtl/bottle_filler.sv | 178 +++++++++++++++++
 tb/tb_bottle_filler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bottle_filler_if.sv
`default_nettype none
// ============================================================================
// Module   : bottle_filler_if
// Desc     : Control, capacity and bottle-count signals of the pill filler
// Revision : 1.0
// ============================================================================
interface bottle_filler_if;
  logic       EN_work;
  logic       EN_set;
  logic       set;
  logic       start;
  logic       pill;
  logic       bottle_ready;
  logic [3:0] maxL;
  logic [3:0] maxH;
  logic [3:0] nowL;
  logic [3:0] nowH;
  logic       isWork;
  logic       bottle_done;
  logic       req_bottle;
  logic       err;

  // master: the filler itself; slave: controller, conveyor and downstream counter
  modport master (
    input  EN_work, EN_set, set, start, pill, bottle_ready, maxL, maxH,
    output nowL, nowH, isWork, bottle_done, req_bottle, err
  );

  modport slave (
    output EN_work, EN_set, set, start, pill, bottle_ready, maxL, maxH,
    input  nowL, nowH, isWork, bottle_done, req_bottle, err
  );
endinterface
`default_nettype wire

// File: rtl/bottle_filler.sv
`default_nettype none
// ============================================================================
// Module   : bottle_filler
// Desc     : BCD pill counter per bottle with capacity compare and bottle swap
// Revision : 1.0
// ============================================================================
module bottle_filler #(
  parameter int SWAP_CYCLES = 4
) (
  input wire              CLK,
  input wire              RST_n,
  bottle_filler_if.master bus
);
  localparam logic [3:0] c_SWAP_MAX = 4'(SWAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_FILL = 3'd2,
    S_FULL = 3'd3,
    S_SWAP = 3'd4
  } state_t;

  state_t     r_state, w_state;
  logic [7:0] r_cap, w_cap;
  logic [3:0] r_now_l, w_now_l;
  logic [3:0] r_now_h, w_now_h;
  logic [3:0] r_swap_cnt, w_swap_cnt;
  logic       r_is_work, w_is_work;
  logic       r_done, w_done;
  logic       r_req, w_req;
  logic       r_err, w_err;
  logic       r_pill_q, w_pill_q;

  logic       w_clear;
  logic       w_pill_edge;
  logic       w_cap_ok;
  logic [3:0] w_inc_l, w_inc_h;
  logic [3:0] w_swap_inc;

  assign w_clear     = bus.EN_set & bus.set;
  assign w_pill_edge = bus.pill & ~r_pill_q;
  assign w_cap_ok    = (bus.maxH <= 4'd9) && (bus.maxL <= 4'd9) &&
                       ({bus.maxH, bus.maxL} != 8'h00);
  assign w_inc_l     = (r_now_l == 4'd9) ? 4'd0 : r_now_l + 4'd1;
  assign w_inc_h     = (r_now_l == 4'd9) ? r_now_h + 4'd1 : r_now_h;
  assign w_swap_inc  = (r_swap_cnt == c_SWAP_MAX) ? r_swap_cnt : r_swap_cnt + 4'd1;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= S_IDLE;
      r_cap      <= 8'h00;
      r_now_l    <= 4'd0;
      r_now_h    <= 4'd0;
      r_swap_cnt <= 4'd0;
      r_is_work  <= 1'b0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_err      <= 1'b0;
      r_pill_q   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cap      <= w_cap;
      r_now_l    <= w_now_l;
      r_now_h    <= w_now_h;
      r_swap_cnt <= w_swap_cnt;
      r_is_work  <= w_is_work;
      r_done     <= w_done;
      r_req      <= w_req;
      r_err      <= w_err;
      r_pill_q   <= w_pill_q;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cap      = r_cap;
    w_now_l    = r_now_l;
    w_now_h    = r_now_h;
    w_swap_cnt = r_swap_cnt;
    w_is_work  = r_is_work;
    w_done     = r_done;
    w_req      = r_req;
    w_err      = r_err;
    w_pill_q   = bus.pill;

    if (w_clear) begin
      w_state    = S_IDLE;
      w_cap      = 8'h00;
      w_now_l    = 4'd0;
      w_now_h    = 4'd0;
      w_swap_cnt = 4'd0;
      w_is_work  = 1'b0;
      w_done     = 1'b0;
      w_req      = 1'b0;
      w_err      = 1'b0;
      w_pill_q   = 1'b0;
    end else if (!bus.EN_work) begin
      w_is_work = 1'b0;
      w_done    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_is_work = 1'b0;
          w_done    = 1'b0;
          w_req     = 1'b0;
          if (bus.start) begin
            w_cap = {bus.maxH, bus.maxL};
            if (w_cap_ok) begin
              w_state = S_WAIT;
              w_req   = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end
        end
        S_WAIT: begin
          w_is_work = 1'b0;
          w_done    = 1'b0;
          w_req     = 1'b1;
          if (bus.bottle_ready) begin
            w_state   = S_FILL;
            w_now_l   = 4'd0;
            w_now_h   = 4'd0;
            w_req     = 1'b0;
            w_is_work = 1'b1;
          end
        end
        S_FILL: begin
          w_is_work = 1'b1;
          w_done    = 1'b0;
          if (w_pill_edge) begin
            w_now_l = w_inc_l;
            w_now_h = w_inc_h;
            if ({w_inc_h, w_inc_l} == r_cap) begin
              w_state = S_FULL;
              w_done  = 1'b1;
            end
          end
        end
        S_FULL: begin
          w_state    = S_SWAP;
          w_is_work  = 1'b0;
          w_done     = 1'b0;
          w_req      = 1'b1;
          w_swap_cnt = 4'd0;
        end
        S_SWAP: begin
          // counter holds completed SWAP cycles, so SWAP lasts at least SWAP_CYCLES cycles
          w_is_work  = 1'b0;
          w_done     = 1'b0;
          w_swap_cnt = w_swap_inc;
          if ((w_swap_inc == c_SWAP_MAX) && bus.bottle_ready) begin
            w_state   = S_FILL;
            w_now_l   = 4'd0;
            w_now_h   = 4'd0;
            w_req     = 1'b0;
            w_is_work = 1'b1;
          end
        end
        default: begin
          w_state   = S_IDLE;
          w_is_work = 1'b0;
          w_done    = 1'b0;
          w_req     = 1'b0;
        end
      endcase
    end
  end

  assign bus.nowL        = r_now_l;
  assign bus.nowH        = r_now_h;
  assign bus.isWork      = r_is_work;
  assign bus.bottle_done = r_done;
  assign bus.req_bottle  = r_req;
  assign bus.err         = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bottle_filler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bottle_filler
// Desc     : Directed and random stimulus against a behavioural filler model
// Revision : 1.0
// ============================================================================
module tb_bottle_filler;
  localparam int c_SWAP = 4;
  localparam int M_IDLE = 0, M_WAIT = 1, M_FILL = 2, M_FULL = 3, M_SWAP = 4;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // behavioural model: decimal count, phase id and swap cycles completed
  int   m_phase, m_cnt, m_cap, m_swaps;
  bit   m_work, m_done, m_req, m_err, m_pill_q;

  bottle_filler_if bus ();

  bottle_filler #(.SWAP_CYCLES(c_SWAP)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase  = M_IDLE;
    m_cnt    = 0;
    m_cap    = 0;
    m_swaps  = 0;
    m_work   = 0;
    m_done   = 0;
    m_req    = 0;
    m_err    = 0;
    m_pill_q = 0;
  endtask

  task automatic model_step();
    bit edge_seen;
    edge_seen = bus.pill && !m_pill_q;
    if (!RST_n || (bus.EN_set && bus.set)) begin
      m_reset();
      return;
    end
    m_pill_q = bus.pill;
    if (!bus.EN_work) begin
      m_work = 0;
      m_done = 0;
      return;
    end
    m_done = 0;
    case (m_phase)
      M_IDLE: begin
        m_work = 0;
        m_req  = 0;
        if (bus.start) begin
          m_cap = int'(bus.maxH) * 10 + int'(bus.maxL);
          if (bus.maxH > 9 || bus.maxL > 9 || m_cap == 0) m_err = 1;
          else begin
            m_phase = M_WAIT;
            m_req   = 1;
          end
        end
      end
      M_WAIT: begin
        m_work = 0;
        m_req  = 1;
        if (bus.bottle_ready) begin
          m_phase = M_FILL; m_cnt = 0; m_req = 0; m_work = 1;
        end
      end
      M_FILL: begin
        m_work = 1;
        if (edge_seen) begin
          m_cnt++;
          if (m_cnt == m_cap) begin
            m_phase = M_FULL;
            m_done  = 1;
          end
        end
      end
      M_FULL: begin
        m_phase = M_SWAP; m_work = 0; m_req = 1; m_swaps = 0;
      end
      default: begin
        m_work = 0;
        m_swaps++;
        if (m_swaps >= c_SWAP && bus.bottle_ready) begin
          m_phase = M_FILL; m_cnt = 0; m_req = 0; m_work = 1;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check_val("nowL",        8'(bus.nowL),        8'(m_cnt % 10));
    check_val("nowH",        8'(bus.nowH),        8'(m_cnt / 10));
    check_val("isWork",      8'(bus.isWork),      8'(m_work));
    check_val("bottle_done", 8'(bus.bottle_done), 8'(m_done));
    check_val("req_bottle",  8'(bus.req_bottle),  8'(m_req));
    check_val("err",         8'(bus.err),         8'(m_err));
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pill_edges(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pill = 1'b1; step();
      bus.pill = 1'b0; step();
    end
  endtask

  task automatic start_cap(input logic [3:0] h, input logic [3:0] l);
    bus.maxH = h; bus.maxL = l; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    int got;
    bus.EN_work = 1'b1; bus.EN_set = 1'b0; bus.set = 1'b0; bus.start = 1'b0;
    bus.pill = 1'b0; bus.bottle_ready = 1'b0; bus.maxL = 4'd0; bus.maxH = 4'd0;
    m_reset();
    #2;
    compare_all();
    step();
    RST_n = 1'b1;
    step();

    // capacity 12, counting through the BCD carry
    start_cap(4'd1, 4'd2);
    bus.bottle_ready = 1'b1; step();
    bus.bottle_ready = 1'b0;
    pill_edges(11);
    bus.pill = 1'b1; step();
    check_val("full_at_12", {bus.nowH, bus.nowL}, 8'h12);
    check_val("done_pulse", 8'(bus.bottle_done & bus.isWork), 8'd1);

    // swap with bottle_ready held and pills toggling
    bus.bottle_ready = 1'b1;
    got = 0;
    for (int n = 1; n <= 40 && got == 0; n++) begin
      bus.pill = ~bus.pill;
      step();
      if (bus.isWork) got = n;
    end
    check_val("swap_len", 8'(got), 8'(c_SWAP + 1));
    check_val("refill_cnt", {bus.nowH, bus.nowL}, 8'h00);
    bus.bottle_ready = 1'b0; bus.pill = 1'b0; step();

    // pause at count 05
    pill_edges(5);
    bus.EN_work = 1'b0;
    for (int i = 0; i < 5; i++) begin bus.pill = ~bus.pill; step(); end
    check_val("pause_work", 8'(bus.isWork), 8'd0);
    bus.EN_work = 1'b1; bus.pill = 1'b0; step();
    pill_edges(1);
    check_val("pause_cnt", {bus.nowH, bus.nowL}, 8'h06);

    // asynchronous reset at count 07
    pill_edges(1);
    #2 RST_n = 1'b0;
    #1 m_reset();
    compare_all();
    step();
    RST_n = 1'b1;
    step();

    // invalid capacities and clear of err
    start_cap(4'd0, 4'd10);
    check_val("err_maxL10", 8'(bus.err), 8'd1);
    step();
    bus.EN_set = 1'b1; bus.set = 1'b1; step();
    bus.EN_set = 1'b0; bus.set = 1'b0;
    check_val("err_clr", 8'(bus.err), 8'd0);
    start_cap(4'd0, 4'd0);
    check_val("err_cap00", 8'(bus.err), 8'd1);
    bus.EN_set = 1'b1; bus.set = 1'b1; step();
    bus.EN_set = 1'b0; bus.set = 1'b0;

    // capacity 01: clear beats a simultaneous pill, then a clean rerun
    start_cap(4'd0, 4'd1);
    bus.bottle_ready = 1'b1; step();
    bus.bottle_ready = 1'b0;
    bus.pill = 1'b1; bus.EN_set = 1'b1; bus.set = 1'b1; bus.start = 1'b1; step();
    bus.EN_set = 1'b0; bus.set = 1'b0; bus.start = 1'b0; bus.pill = 1'b0;
    check_val("clr_win_cnt", {bus.nowH, bus.nowL}, 8'h00);
    start_cap(4'd0, 4'd1);
    bus.bottle_ready = 1'b1; step();
    bus.bottle_ready = 1'b0;
    bus.pill = 1'b1; step();
    check_val("cap01_full", 8'(bus.bottle_done), 8'd1);
    check_val("cap01_cnt", {bus.nowH, bus.nowL}, 8'h01);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.EN_work      = ($urandom % 10) != 0;
      bus.EN_set       = ($urandom % 4) == 0;
      bus.set          = ($urandom % 40) == 0;
      bus.start        = ($urandom % 8) == 0;
      bus.pill         = 1'($urandom % 2);
      bus.bottle_ready = ($urandom % 3) == 0;
      bus.maxH         = (($urandom % 16) == 0) ? 4'($urandom % 16) : 4'($urandom % 2);
      bus.maxL         = (($urandom % 16) == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
